ps2_rx_framer: RTL

PS2_RX_FRAMER -- requirements
Module: ps2_rx_framer

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_byte_fifo.sv | 62 ++++++
 rtl/ps2_rx_framer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: receiver FSM states,
// rejection causes, frame geometry and the odd-parity test.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_PARITY  = 2'd1,
    ERR_STOP    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } ps2_err_t;

  // start + 8 data + parity + stop
  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned DATA_BITS  = FRAME_BITS - 3;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Received-byte FIFO with valid/ready pop and a sticky overflow flag.
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   push          write request for push_data
//   pop_req       consumer ready; a pop happens only while valid is high
//   rd_data       head entry (0x00 while empty)
//   valid         FIFO non-empty
//   overflow      sticky: a push was dropped because the FIFO was full
module ps2_byte_fifo #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop_req,
  output logic [7:0] rd_data,
  output logic       valid,
  output logic       overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          pop;
  logic          wr_en;

  assign valid   = (count != '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = valid & pop_req;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en   = push & (~full | pop);
  assign rd_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push & full & ~pop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/ps2_rx_framer.sv
// PS/2 keyboard receiver: synchronizes PS2_CLK/PS2_DAT, frames 11-bit
// device-to-host words, checks odd parity and stop bit, aborts stalled
// frames, and queues accepted bytes in a FIFO.
// Ports:
//   CLOCK_50          system clock
//   Reset             asynchronous active-high reset
//   PS2_CLK, PS2_DAT  raw keyboard lines (asynchronous)
//   rx_data/rx_valid/rx_ready  byte stream out of the FIFO
//   rx_err            one-cycle pulse on frame rejection
//   err_code          cause of the last rejection (ps2_err_t encoding)
//   overflow          sticky: accepted byte dropped on full FIFO
module ps2_rx_framer
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_err,
  output logic [1:0] err_code,
  output logic       overflow
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_meta, clk_s, clk_prev;
  logic          dat_meta, dat_s;
  logic          fall;
  ps2_state_t    state, state_nxt;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt;
  logic          par_q;
  logic [TW-1:0] to_cnt;
  logic          timeout;
  logic          push;
  logic          reject;
  ps2_err_t      rej_code;
  ps2_err_t      err_q;

  // Two-flop synchronizers; reset to the idle-high bus level.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      clk_meta <= 1'b1;
      clk_s    <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      dat_s    <= 1'b1;
    end else begin
      clk_meta <= PS2_CLK;
      clk_s    <= clk_meta;
      clk_prev <= clk_s;
      dat_meta <= PS2_DAT;
      dat_s    <= dat_meta;
    end
  end

  assign fall    = clk_prev & ~clk_s;
  assign timeout = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Stop bit is checked before parity so a double failure reports ERR_STOP.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    reject    = 1'b0;
    rej_code  = ERR_NONE;
    if (timeout) begin
      state_nxt = IDLE;
      reject    = 1'b1;
      rej_code  = ERR_TIMEOUT;
    end else if (fall) begin
      unique case (state)
        IDLE:   if (!dat_s) state_nxt = DATA;
        DATA:   if (bit_cnt == 3'(DATA_BITS - 1)) state_nxt = PARITY;
        PARITY: state_nxt = STOP;
        STOP: begin
          state_nxt = IDLE;
          if (!dat_s) begin
            reject   = 1'b1;
            rej_code = ERR_STOP;
          end else if (!odd_parity_ok(shift_q, par_q)) begin
            reject   = 1'b1;
            rej_code = ERR_PARITY;
          end else begin
            push = 1'b1;
          end
        end
      endcase
    end
  end

  // Data bits arrive LSB first, so shift in from the top.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      shift_q <= '0;
      bit_cnt <= '0;
      par_q   <= 1'b0;
    end else if (fall) begin
      if (state == IDLE) bit_cnt <= '0;
      if (state == DATA) begin
        shift_q <= {dat_s, shift_q[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == PARITY) par_q <= dat_s;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset)                                   to_cnt <= '0;
    else if (state == IDLE || fall || timeout)   to_cnt <= '0;
    else                                         to_cnt <= to_cnt + TW'(1);
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      rx_err <= 1'b0;
      err_q  <= ERR_NONE;
    end else begin
      rx_err <= reject;
      if (reject) err_q <= rej_code;
    end
  end

  assign err_code = err_q;

  ps2_byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLOCK_50),
    .rst      (Reset),
    .push     (push),
    .push_data(shift_q),
    .pop_req  (rx_ready),
    .rd_data  (rx_data),
    .valid    (rx_valid),
    .overflow (overflow)
  );

endmodule
